// File: rtl/demo_abc_pkg.sv
//------------------------------------------------------------------------------
// Module   : demo_abc_pkg
// Brief    : Shared types and constants for the a/b/c transaction sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demo_abc_pkg;

  // Sequencer states; the encoding is fixed so the outputs decode cleanly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST_A = 2'd1,
    ST_B = 2'd2,
    ST_C = 2'd3
  } state_t;

  // Legal parameter ranges for the sequencer.
  localparam int BLEN_MIN = 1;
  localparam int BLEN_MAX = 15;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 4;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : demo_abc_pkg

`default_nettype wire

// File: rtl/demo_abc_sequencer_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin selector. The search begins at index
//            ptr and wraps around; the lowest requesting index at or above ptr
//            wins, otherwise the lowest requesting index overall.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pick;

  // Split requests into those at/above the pointer and pick the lowest one,
  // falling back to the full request vector when the upper part is empty.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (i >= int'(ptr));
    end
    w_hi   = req & w_mask;
    w_pick = (|w_hi) ? w_hi : req;
    gnt    = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
    any = |req;
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/demo_abc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : demo_abc_sequencer
// Brief    : Arbitrates among NREQ requesters and runs one a / b[*BLEN] / c
//            transaction per grant. Back-to-back grants go straight from c to
//            the next a without passing through IDLE.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demo_abc_sequencer
  import demo_abc_pkg::*;
#(
  parameter int BLEN = 2,
  parameter int NREQ = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            busy
);

  localparam int CW = $clog2(BLEN + 1);
  localparam int PW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_win;
  logic [PW-1:0]   r_ptr;

  logic [NREQ-1:0] w_arb_gnt;
  logic [PW-1:0]   w_arb_idx;
  logic            w_arb_any;
  logic            w_enter_a;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (req),
    .ptr  (r_ptr),
    .gnt  (w_arb_gnt),
    .idx  (w_arb_idx),
    .any  (w_arb_any)
  );

  // Next-state and output decode; every output comes from the registered
  // state and latched winner so the live req vector never leaks through.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_next = ST_A;
      ST_A:    w_next = ST_B;
      ST_B:    if (r_cnt == CW'(1)) w_next = ST_C;
      ST_C:    w_next = w_arb_any ? ST_A : IDLE;
      default: w_next = IDLE;
    endcase
    w_enter_a = (w_next == ST_A);
    a    = (r_state == ST_A);
    b    = (r_state == ST_B);
    c    = (r_state == ST_C);
    busy = (r_state != IDLE);
    gnt  = (r_state == ST_A) ? r_win : '0;
    done = (r_state == ST_C) ? r_win : '0;
  end

  // State register plus the winner/pointer latch taken on entry to ST_A;
  // reset returns straight to IDLE so an in-flight transaction ends silently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter_a) begin
        r_win <= w_arb_gnt;
        r_ptr <= PW'(rr_next(int'(w_arb_idx), NREQ));
      end
    end
  end

  // Body-length counter: loaded in ST_A, counts down in ST_B and holds at 1
  // so it can never wrap while b is active.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_A) begin
      r_cnt <= CW'(BLEN);
    end else if ((r_state == ST_B) && (r_cnt > CW'(1))) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule : demo_abc_sequencer

`default_nettype wire

// File: tb/tb_demo_abc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_demo_abc_sequencer
// Brief    : Scoreboard bench for demo_abc_sequencer (BLEN=2 and BLEN=5).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demo_abc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req0, req5;
  logic [1:0] gnt0, done0, gnt5, done5;
  logic       a0, b0, c0, busy0, a5, b5, c5, busy5;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;   // 0 = a, 1 = b, 2 = c
    logic [1:0] vec;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q5[$];

  always #5 clock = ~clock;

  // Cycle index: equals n throughout the cycle following the n-th posedge.
  always @(posedge clock) cyc <= cyc + 1;

  demo_abc_sequencer #(.BLEN(2), .NREQ(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req0), .gnt(gnt0), .done(done0),
    .a(a0), .b(b0), .c(c0), .busy(busy0)
  );

  demo_abc_sequencer #(.BLEN(5), .NREQ(2)) dut5 (
    .clock(clock), .reset_n(reset_n), .req(req5), .gnt(gnt5), .done(done5),
    .a(a5), .b(b5), .c(c5), .busy(busy5)
  );

  // Protocol properties on both instances, inactive during reset.
  a_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0({a0, b0, c0}))
    else begin errors++; $display("FAIL onehot_abc dut: a/b/c=%b%b%b required at most one", a0, b0, c0); end
  a_gnt0: assert property (@(posedge clock) disable iff (!reset_n) (|gnt0) |-> a0)
    else begin errors++; $display("FAIL gnt_implies_a dut: gnt=%b a=%b required a=1", gnt0, a0); end
  a_rose0: assert property (@(posedge clock) disable iff (!reset_n) $rose(a0) |=> b0)
    else begin errors++; $display("FAIL a_then_b dut: b=%b required 1", b0); end
  a_fell0: assert property (@(posedge clock) disable iff (!reset_n) $fell(b0) |-> c0)
    else begin errors++; $display("FAIL b_then_c dut: c=%b required 1", c0); end
  a_onehot5: assert property (@(posedge clock) disable iff (!reset_n) $onehot0({a5, b5, c5}))
    else begin errors++; $display("FAIL onehot_abc dut5: a/b/c=%b%b%b required at most one", a5, b5, c5); end
  a_gnt5: assert property (@(posedge clock) disable iff (!reset_n) (|gnt5) |-> a5)
    else begin errors++; $display("FAIL gnt_implies_a dut5: gnt=%b a=%b required a=1", gnt5, a5); end
  a_fell5: assert property (@(posedge clock) disable iff (!reset_n) $fell(b5) |-> c5)
    else begin errors++; $display("FAIL b_then_c dut5: c=%b required 1", c5); end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push one full expected transaction (a, BLEN b cycles, c) starting at t_a.
  task automatic push_txn(input int id, input int t_a, input logic [1:0] vec, input int blen);
    exp_t e;
    e.vec = vec;
    e.kind = 0; e.at = t_a;
    if (id == 0) q0.push_back(e); else q5.push_back(e);
    for (int k = 1; k <= blen; k++) begin
      e.kind = 1; e.at = t_a + k;
      if (id == 0) q0.push_back(e); else q5.push_back(e);
    end
    e.kind = 2; e.at = t_a + blen + 1;
    if (id == 0) q0.push_back(e); else q5.push_back(e);
  endtask

  task automatic push_one(input int id, input int kind, input int at, input logic [1:0] vec);
    exp_t e;
    e.kind = kind; e.at = at; e.vec = vec;
    if (id == 0) q0.push_back(e); else q5.push_back(e);
  endtask

  task automatic mon(input int id, input logic a, input logic b, input logic c,
                     input logic busy, input logic [1:0] gnt, input logic [1:0] done);
    exp_t e;
    int   kind;
    int   qsz;
    chk($sformatf("busy%0d", id), int'(busy), int'(a | b | c));
    if (!a) chk($sformatf("gnt_quiet%0d", id), int'(gnt), 0);
    if (!c) chk($sformatf("done_quiet%0d", id), int'(done), 0);
    if (a | b | c) begin
      kind = a ? 0 : (b ? 1 : 2);
      qsz  = (id == 0) ? q0.size() : q5.size();
      checks++;
      if (qsz == 0) begin
        errors++;
        $display("FAIL unexpected_event%0d: got kind %0d at cycle %0d, required none", id, kind, cyc);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q5.pop_front();
        if (kind != e.kind || cyc != e.at) begin
          errors++;
          $display("FAIL event%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   id, kind, cyc, e.kind, e.at);
        end
        if (kind == 0) chk($sformatf("gnt%0d", id), int'(gnt), int'(e.vec));
        if (kind == 2) chk($sformatf("done%0d", id), int'(done), int'(e.vec));
      end
    end
  endtask

  // Monitor: sample both DUTs mid-cycle and compare against the queues.
  always @(negedge clock) begin
    mon(0, a0, b0, c0, busy0, gnt0, done0);
    mon(1, a5, b5, c5, busy5, gnt5, done5);
  end

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int t;
    reset_n = 1'b0;
    req0    = 2'b00;
    req5    = 2'b00;
    step(2);
    reset_n = 1'b1;

    // Single request: req=01 pulsed at cycle 3.
    step(1);
    t = cyc;
    req0 = 2'b01;
    push_txn(0, t + 1, 2'b01, 2);
    step(1);
    req0 = 2'b00;
    step(7);

    // Contention from a fresh reset: 01, 10, 01 back to back.
    do_reset();
    t = cyc;
    req0 = 2'b11;
    push_txn(0, t + 1, 2'b01, 2);
    push_txn(0, t + 5, 2'b10, 2);
    push_txn(0, t + 9, 2'b01, 2);
    step(9);
    req0 = 2'b00;
    step(6);

    // Withdrawn request with mid-flight req noise; pointer now favours 1.
    t = cyc;
    req0 = 2'b01;
    push_txn(0, t + 1, 2'b01, 2);
    step(1);
    req0 = 2'b00;
    step(1);
    req0 = 2'b10;
    step(1);
    req0 = 2'b00;
    step(6);

    // Reset during the body: a and first b only, then silence.
    do_reset();
    t = cyc;
    req0 = 2'b01;
    push_one(0, 0, t + 1, 2'b01);
    push_one(0, 1, t + 2, 2'b00);
    step(1);
    req0 = 2'b00;
    step(1);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(5);

    // Long body on the BLEN=5 instance.
    t = cyc;
    req5 = 2'b10;
    push_txn(1, t + 1, 2'b10, 5);
    step(1);
    req5 = 2'b00;
    step(10);

    chk("q0_drained", q0.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demo_abc_sequencer

`default_nettype wire

// File: doc/demo_abc_sequencer.md
DEMO_ABC_SEQUENCER -- requirements
Module: demo_abc_sequencer

Interface
REQ-001 Parameter BLEN, default 2, sets the number of consecutive cycles b is held high; legal range 1..15.
REQ-002 Parameter NREQ, default 2, sets the number of requesters; legal range 2..4.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 req  input  NREQ  level request per requester; bit i high = requester i wants one a/b/c transaction.
REQ-006 gnt  output  NREQ  one-hot, one-cycle pulse marking the winning requester, coincident with a.
REQ-007 done  output  NREQ  one-hot, one-cycle pulse to the granted requester, coincident with c.
REQ-008 a  output  1  start strobe, one cycle high per transaction.
REQ-009 b  output  1  body strobe, high for exactly BLEN consecutive cycles per transaction.
REQ-010 c  output  1  completion strobe, one cycle high per transaction.
REQ-011 busy  output  1  high in every cycle a, b or c is high.

Function
REQ-012 The FSM SHALL have the states IDLE, ST_A, ST_B and ST_C, with all outputs decoded from registered state.
REQ-013 IDLE SHALL transition to ST_A on a cycle with req != 0; otherwise it SHALL stay in IDLE.
REQ-014 ST_A SHALL drive a=1 and gnt=one-hot winner, load the b counter with BLEN, and then go to ST_B.
REQ-015 ST_B SHALL drive b=1 and decrement the counter each cycle, going to ST_C when the counter equals 1.
REQ-016 ST_C SHALL drive c=1 and done=one-hot latched winner, then go to ST_A if req != 0, else to IDLE.
REQ-017 Timing: req sampled high in IDLE at cycle t gives a at t+1, b at t+2..t+1+BLEN, c at t+2+BLEN.
REQ-018 Every transaction SHALL satisfy $rose(a) |=> b[*BLEN] ##1 c, with no gap cycle between the last b and c.
REQ-019 a SHALL be low in the cycle before every a pulse, so each transaction start is a rising edge of a.
REQ-020 Back-to-back transactions SHALL run at one per BLEN+2 cycles, with no IDLE cycle between them.
REQ-021 Arbitration SHALL be round-robin: the search starts at the requester after the last winner, and requester 0 is favoured after reset.
REQ-022 The winner SHALL be latched at ST_A entry, and the latched winner SHALL be the only value driving gnt and done.
REQ-023 Changes to req during ST_A, ST_B or ST_C SHALL NOT alter the transaction in flight.
REQ-024 A requester that drops req before its c SHALL still receive its done pulse.
REQ-025 Simultaneous requests SHALL be served strictly in turn.
REQ-026 At most one of a, b and c SHALL be high in any cycle.
REQ-027 The counter width SHALL be $clog2(BLEN+1), and the counter SHALL never wrap below 1 while in ST_B.

Reset
REQ-028 While reset_n=0, the state SHALL be IDLE and the outputs SHALL be a=b=c=busy=0, gnt=0 and done=0.
REQ-029 Reset SHALL clear the counter and set the round-robin pointer so that requester 0 has priority.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction at the next edge with no c or done pulse.
REQ-031 After reset_n returns high, the first a SHALL occur no earlier than one cycle after a req sampled in IDLE.

Structure
REQ-032 Package demo_abc_pkg SHALL hold the state enum typedef and the BLEN and NREQ legal-range constants.
REQ-033 Round-robin selection SHALL be a sub-module named rr_arbiter, purely combinational from req and the pointer.
REQ-034 The pointer register SHALL reside in demo_abc_sequencer.

Verification
REQ-035 Scenario "single request": BLEN=2, req=01 pulsed at cycle 3 -> a@4, gnt=01@4, b@5-6, c@7, done=01@7, busy@4-7.
REQ-036 Scenario "contention": BLEN=2, req=11 held from cycle 2 -> gnt=01@3, done=01@6, gnt=10@7, done=10@10, gnt=01@11.
REQ-037 Scenario "long body": BLEN=5, req=10 at cycle 1 -> b high for cycles 3-7 and c@8.
REQ-038 Scenario "mid-sequence reset": BLEN=2, req=01 at 1, reset_n=0 at cycle 3 -> outputs zero at cycle 4, and no c or done.
REQ-039 Scenario "request withdrawn": req=01 for one cycle only -> the full a/b/c sequence runs and done=01 is still pulsed.
REQ-040 The property of REQ-018, the one-hot property of REQ-026 and "gnt implies a" SHALL be bound as assertions throughout, disabled while reset_n=0.
